// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: combinational grant, lock ownership, 1-cycle reads.
// Define MEM_ARB_FIXED_PRIO_EN for fixed m0 priority; default build is round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t state_q, state_d;
    logic   rv0_q, rv0_d;
    logic   rv1_q, rv1_d;
    logic   g0, g1;

`ifndef MEM_ARB_FIXED_PRIO_EN
    // 1 = requester 1 was granted most recently
    logic   last_q, last_d;
`endif

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    g0 = 1'b1;
`else
                    g0 = last_q;
                    g1 = !last_q;
`endif
                end else begin
                    g0 = m0_req;
                    g1 = m1_req;
                end
            end
            OWN0:    g0 = m0_req;
            OWN1:    g1 = m1_req;
            default: ;
        endcase
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
        // Owner releases when it drops lock, whether or not it was granted
        unique case (state_q)
            IDLE: begin
                if (g0 && m0_lock)      state_d = OWN0;
                else if (g1 && m1_lock) state_d = OWN1;
            end
            OWN0: if (!m0_lock) state_d = IDLE;
            OWN1: if (!m1_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rv0_d = g0 && !m0_we;
    assign rv1_d = g1 && !m1_we;

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        last_d = last_q;
        if (g1)      last_d = 1'b1;
        else if (g0) last_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rv0_q ? mem_rdata : '0;
    assign m1_rdata  = rv1_q ? mem_rdata : '0;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (g0) begin
            mem_addr  = m0_addr;
            mem_we    = m0_we;
            mem_wdata = m0_wdata;
        end else if (g1) begin
            mem_addr  = m1_addr;
            mem_we    = m1_we;
            mem_wdata = m1_wdata;
        end
    end

endmodule
